// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, issues word reads over a req/ack
// handshake and fills the IF/ID latch, with a one-entry skid for stalls and
// redirect handling that drains an outstanding read before refetching.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic        if_valid
);

    typedef enum logic [1:0] {IDLE, REQ, HOLD, DISCARD} state_t;

    state_t      state, state_nx;
    logic [31:0] pc, pc_nx, pc_inc, redirect_target;
    logic        req_nx, valid_nx;
    logic [31:0] addr_nx, instr_nx, ipc_nx;
    logic        skid_valid, skid_valid_nx;
    logic [31:0] skid_instr, skid_pc, skid_instr_nx, skid_pc_nx;
    logic        slot_free;

    assign pc_inc          = pc + PC_STEP;
    assign redirect_target = redirect_pc & 32'hFFFF_FFFC;
    // The output slot can take new data if it is empty or drains this cycle.
    assign slot_free       = !if_valid || !stall_i;

    // Next-state, next-PC and next-output computation; redirect dominates.
    always_comb begin
        state_nx      = state;
        pc_nx         = pc;
        req_nx        = imem_req;
        addr_nx       = imem_addr;
        instr_nx      = if_instr;
        ipc_nx        = if_pc;
        valid_nx      = if_valid;
        skid_valid_nx = skid_valid;
        skid_instr_nx = skid_instr;
        skid_pc_nx    = skid_pc;

        // A consumed instruction leaves the slot empty unless refilled below.
        if (if_valid && !stall_i) begin
            valid_nx = 1'b0;
        end

        if (redirect_valid) begin
            pc_nx         = redirect_target;
            valid_nx      = 1'b0;
            skid_valid_nx = 1'b0;
            case (state)
                REQ, DISCARD: begin
                    if (imem_ack) begin
                        // Read completes now: drop its data, refetch at target.
                        state_nx = REQ;
                        req_nx   = 1'b1;
                        addr_nx  = redirect_target;
                    end else begin
                        // Keep the old request up until memory answers it.
                        state_nx = DISCARD;
                    end
                end
                default: begin
                    state_nx = REQ;
                    req_nx   = 1'b1;
                    addr_nx  = redirect_target;
                end
            endcase
        end else begin
            case (state)
                IDLE: begin
                    state_nx = REQ;
                    req_nx   = 1'b1;
                    addr_nx  = pc;
                end
                REQ: begin
                    if (imem_ack) begin
                        pc_nx   = pc_inc;
                        addr_nx = pc_inc;
                        if (slot_free) begin
                            instr_nx = imem_rdata;
                            ipc_nx   = pc;
                            valid_nx = 1'b1;
                        end else begin
                            skid_instr_nx = imem_rdata;
                            skid_pc_nx    = pc;
                            skid_valid_nx = 1'b1;
                            state_nx      = HOLD;
                            req_nx        = 1'b0;
                        end
                    end
                end
                HOLD: begin
                    if (!stall_i) begin
                        instr_nx      = skid_instr;
                        ipc_nx        = skid_pc;
                        valid_nx      = skid_valid;
                        skid_valid_nx = 1'b0;
                        state_nx      = REQ;
                        req_nx        = 1'b1;
                        addr_nx       = pc;
                    end
                end
                DISCARD: begin
                    if (imem_ack) begin
                        state_nx = REQ;
                        req_nx   = 1'b1;
                        addr_nx  = pc;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    // Control state and registered outputs, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            imem_req   <= 1'b0;
            imem_addr  <= RESET_PC;
            if_instr   <= 32'd0;
            if_pc      <= 32'd0;
            if_valid   <= 1'b0;
            skid_valid <= 1'b0;
        end else begin
            state      <= state_nx;
            pc         <= pc_nx;
            imem_req   <= req_nx;
            imem_addr  <= addr_nx;
            if_instr   <= instr_nx;
            if_pc      <= ipc_nx;
            if_valid   <= valid_nx;
            skid_valid <= skid_valid_nx;
        end
    end

    // Skid payload needs no reset: it is only read while skid_valid is set.
    always_ff @(posedge clk) begin
        skid_instr <= skid_instr_nx;
        skid_pc    <= skid_pc_nx;
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: cycle-by-cycle stimulus with hand-computed
// expectations, plus a second instance reset near the top of the address map.
module tb_fetch_unit;

    localparam logic [31:0] I0   = 32'h0010_0093;
    localparam logic [31:0] I1   = 32'h0020_0113;
    localparam logic [31:0] I2   = 32'h0030_0193;
    localparam logic [31:0] I3   = 32'h0040_0213;
    localparam logic [31:0] I4   = 32'h0050_0293;
    localparam logic [31:0] I5   = 32'h0060_0313;
    localparam logic [31:0] I6   = 32'h0070_0393;
    localparam logic [31:0] I7   = 32'h0080_0413;
    localparam logic [31:0] I8   = 32'h0090_0493;
    localparam logic [31:0] I9   = 32'h00A0_0513;
    localparam logic [31:0] JUNK = 32'hDEAD_BEEF;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redir;
    logic [31:0] redir_pc;
    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic [31:0] rdata;
    logic [31:0] instr;
    logic [31:0] ipc;
    logic        valid;

    logic        stall2;
    logic        redir2;
    logic [31:0] redir_pc2;
    logic        req2;
    logic [31:0] addr2;
    logic        ack2;
    logic [31:0] rdata2;
    logic [31:0] instr2;
    logic [31:0] ipc2;
    logic        valid2;

    int n_vec;
    int n_miss;

    fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .stall_i        (stall),
        .redirect_valid (redir),
        .redirect_pc    (redir_pc),
        .imem_req       (req),
        .imem_addr      (addr),
        .imem_ack       (ack),
        .imem_rdata     (rdata),
        .if_instr       (instr),
        .if_pc          (ipc),
        .if_valid       (valid)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk            (clk),
        .rst            (rst),
        .stall_i        (stall2),
        .redirect_valid (redir2),
        .redirect_pc    (redir_pc2),
        .imem_req       (req2),
        .imem_addr      (addr2),
        .imem_ack       (ack2),
        .imem_rdata     (rdata2),
        .if_instr       (instr2),
        .if_pc          (ipc2),
        .if_valid       (valid2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs, step past the rising edge, settle.
    task automatic cyc(input logic a, input logic [31:0] d, input logic s,
                       input logic r, input logic [31:0] rp);
        ack      = a;
        rdata    = d;
        stall    = s;
        redir    = r;
        redir_pc = rp;
        @(posedge clk);
        #1;
    endtask

    // Address is compared only while a request is up; instr/pc only while valid.
    task automatic expect_out(input string tag, input logic e_req, input logic [31:0] e_addr,
                              input logic e_valid, input logic [31:0] e_instr,
                              input logic [31:0] e_pc);
        chk({tag, ".req"}, 32'(req), 32'(e_req));
        if (e_req) chk({tag, ".addr"}, addr, e_addr);
        chk({tag, ".valid"}, 32'(valid), 32'(e_valid));
        if (e_valid) begin
            chk({tag, ".instr"}, instr, e_instr);
            chk({tag, ".pc"}, ipc, e_pc);
        end
    endtask

    initial begin
        n_vec     = 0;
        n_miss    = 0;
        rst       = 1'b1;
        ack       = 1'b0;
        rdata     = 32'd0;
        stall     = 1'b0;
        redir     = 1'b0;
        redir_pc  = 32'd0;
        stall2    = 1'b0;
        redir2    = 1'b0;
        redir_pc2 = 32'd0;
        ack2      = 1'b0;
        rdata2    = 32'd0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst.req",   32'(req),   32'd0);
        chk("rst.addr",  addr,       32'd0);
        chk("rst.valid", 32'(valid), 32'd0);
        chk("rst.instr", instr,      32'd0);
        chk("rst.pc",    ipc,        32'd0);
        chk("rst.addr2", addr2,      32'hFFFF_FFFC);

        rst = 1'b0;
        cyc(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        expect_out("first_req", 1'b1, 32'h0, 1'b0, 32'd0, 32'd0);

        // Back-to-back fetch, memory acks every cycle.
        cyc(1'b1, I0, 1'b0, 1'b0, 32'd0);
        expect_out("b2b0", 1'b1, 32'h4, 1'b1, I0, 32'h0);
        cyc(1'b1, I1, 1'b0, 1'b0, 32'd0);
        expect_out("b2b1", 1'b1, 32'h8, 1'b1, I1, 32'h4);
        cyc(1'b1, I2, 1'b0, 1'b0, 32'd0);
        expect_out("b2b2", 1'b1, 32'hC, 1'b1, I2, 32'h8);

        // Three-cycle memory latency: address held, single valid pulse.
        cyc(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        expect_out("lat_w1", 1'b1, 32'hC, 1'b0, 32'd0, 32'd0);
        cyc(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        expect_out("lat_w2", 1'b1, 32'hC, 1'b0, 32'd0, 32'd0);
        cyc(1'b1, I3, 1'b0, 1'b0, 32'd0);
        expect_out("lat_ack", 1'b1, 32'h10, 1'b1, I3, 32'hC);
        cyc(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        expect_out("lat_drain", 1'b1, 32'h10, 1'b0, 32'd0, 32'd0);

        // Stall while a second fetch completes: skid, HOLD, then in-order drain.
        cyc(1'b1, I4, 1'b0, 1'b0, 32'd0);
        expect_out("stl_load", 1'b1, 32'h14, 1'b1, I4, 32'h10);
        cyc(1'b1, I5, 1'b1, 1'b0, 32'd0);
        expect_out("stl_skid", 1'b0, 32'd0, 1'b1, I4, 32'h10);
        for (int k = 0; k < 3; k++) begin
            cyc(1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
            expect_out("stl_hold", 1'b0, 32'd0, 1'b1, I4, 32'h10);
        end
        cyc(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        expect_out("stl_rel", 1'b1, 32'h18, 1'b1, I5, 32'h14);
        cyc(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        expect_out("stl_empty", 1'b1, 32'h18, 1'b0, 32'd0, 32'd0);

        // Redirect with a read outstanding: late ack dropped, refetch at 0x100.
        cyc(1'b0, 32'd0, 1'b0, 1'b1, 32'h103);
        expect_out("dis_enter", 1'b1, 32'h18, 1'b0, 32'd0, 32'd0);
        cyc(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        expect_out("dis_wait", 1'b1, 32'h18, 1'b0, 32'd0, 32'd0);
        cyc(1'b1, JUNK, 1'b0, 1'b0, 32'd0);
        expect_out("dis_drop", 1'b1, 32'h100, 1'b0, 32'd0, 32'd0);
        cyc(1'b1, I6, 1'b0, 1'b0, 32'd0);
        expect_out("dis_new", 1'b1, 32'h104, 1'b1, I6, 32'h100);

        // Redirect coinciding with ack and stall: data dropped, slot cleared.
        cyc(1'b1, JUNK, 1'b1, 1'b1, 32'h200);
        expect_out("rda_drop", 1'b1, 32'h200, 1'b0, 32'd0, 32'd0);
        cyc(1'b1, I7, 1'b0, 1'b0, 32'd0);
        expect_out("rda_new", 1'b1, 32'h204, 1'b1, I7, 32'h200);
        cyc(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        expect_out("rda_idle", 1'b1, 32'h204, 1'b0, 32'd0, 32'd0);

        // PC wrap on the instance reset to 0xFFFF_FFFC.
        ack2   = 1'b1;
        rdata2 = I0;
        cyc(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        chk("wrap.valid0", 32'(valid2), 32'd1);
        chk("wrap.pc0",    ipc2,        32'hFFFF_FFFC);
        chk("wrap.instr0", instr2,      I0);
        chk("wrap.addr1",  addr2,       32'h0);
        rdata2 = I1;
        cyc(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        chk("wrap.pc1",    ipc2,        32'h0);
        chk("wrap.addr2",  addr2,       32'h4);
        ack2 = 1'b0;

        // Asynchronous reset mid-request, then a stale ack into IDLE.
        cyc(1'b1, I8, 1'b0, 1'b0, 32'd0);
        expect_out("pre_rst", 1'b1, 32'h208, 1'b1, I8, 32'h204);
        rst = 1'b1;
        #1;
        chk("arst.req",   32'(req),   32'd0);
        chk("arst.addr",  addr,       32'd0);
        chk("arst.valid", 32'(valid), 32'd0);
        chk("arst.instr", instr,      32'd0);
        chk("arst.pc",    ipc,        32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc(1'b1, JUNK, 1'b0, 1'b0, 32'd0);
        expect_out("idle_ign", 1'b1, 32'h0, 1'b0, 32'd0, 32'd0);
        cyc(1'b1, I9, 1'b0, 1'b0, 32'd0);
        expect_out("post_rst", 1'b1, 32'h4, 1'b1, I9, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
